ms_qspi_xip_ahbl_arbiter: RTL

- Two-master AHB-Lite read arbiter in front of the single AHB-Lite slave port of the QSPI XIP cache.
- M0 is the instruction-fetch master; M1 is the data master.
- Each master's address phase is captured into a pending register and forwarded to the cache one cycle later, in arbitration order.
- Read data and ready are routed back to the owning master. The cache sees exactly one master at a time.

---
 rtl/ms_qspi_xip_ahbl_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ms_qspi_xip_ahbl_arbiter.sv
`timescale 1ns/1ps
// Two-master AHB-Lite read arbiter (M0 = instruction fetch, M1 = data) in front of the XIP cache slave port.
// Optional macro MS_QSPI_XIP_ARB_WR_ERR_EN adds HRESP_M0/HRESP_M1 and answers writes with a two-cycle ERROR.
module ms_qspi_xip_ahbl_arbiter #(
    parameter int PRIO_MODE = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_M0,
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic        HREADY_M0,
    output logic        HREADYOUT_M0,
    output logic [31:0] HRDATA_M0,
`ifdef MS_QSPI_XIP_ARB_WR_ERR_EN
    output logic        HRESP_M0,
    output logic        HRESP_M1,
`endif
    input  logic        HSEL_M1,
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic        HREADY_M1,
    output logic        HREADYOUT_M1,
    output logic [31:0] HRDATA_M1,
    output logic        S_HSEL,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic        S_HREADY,
    input  logic        S_HREADYOUT,
    input  logic [31:0] S_HRDATA
);
    typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_pend, w_pend_nxt, w_cap, w_err_stall;
    logic [31:0] r_paddr0, r_paddr1;
    logic        r_owner, r_last;
    logic        w_grant, w_win;
    logic        w_unused;

    // SEQ and NONSEQ are treated alike, so only HTRANS[1] matters
    assign w_cap[0] = HSEL_M0 & HTRANS_M0[1] & HREADY_M0 & ~HWRITE_M0;
    assign w_cap[1] = HSEL_M1 & HTRANS_M1[1] & HREADY_M1 & ~HWRITE_M1;
    assign w_unused = HTRANS_M0[0] ^ HTRANS_M1[0];
    assign S_HWRITE = 1'b0;

`ifdef MS_QSPI_XIP_ARB_WR_ERR_EN
    logic [1:0] r_err1, r_err2, w_wcap;

    assign w_wcap[0] = HSEL_M0 & HTRANS_M0[1] & HREADY_M0 & HWRITE_M0;
    assign w_wcap[1] = HSEL_M1 & HTRANS_M1[1] & HREADY_M1 & HWRITE_M1;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_err1 <= 2'b00;
            r_err2 <= 2'b00;
        end else begin
            r_err1 <= w_wcap;
            r_err2 <= r_err1;
        end
    end

    assign HRESP_M0    = r_err1[0] | r_err2[0];
    assign HRESP_M1    = r_err1[1] | r_err2[1];
    assign w_err_stall = r_err1;
`else
    assign w_err_stall = 2'b00;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_pend   <= 2'b00;
            r_paddr0 <= 32'h0;
            r_paddr1 <= 32'h0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_cap[0]) r_paddr0 <= HADDR_M0;
            if (w_cap[1]) r_paddr1 <= HADDR_M1;
            if (w_grant) begin
                r_owner <= w_win;
                r_last  <= w_win;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win       = r_pend[1];
        if (r_pend == 2'b11) begin
            if (PRIO_MODE == 0)      w_win = 1'b0;
            else if (PRIO_MODE == 1) w_win = 1'b1;
            else                     w_win = ~r_last;
        end

        // A completing data phase and the next address phase share a cycle
        w_grant  = (|r_pend) & ((r_state == ST_IDLE) | S_HREADYOUT);
        S_HSEL   = w_grant;
        S_HTRANS = w_grant ? 2'b10 : 2'b00;
        S_HADDR  = 32'h0;
        if (w_grant) S_HADDR = w_win ? r_paddr1 : r_paddr0;
        S_HREADY = (r_state == ST_DATA) ? S_HREADYOUT : 1'b1;

        w_pend_nxt = r_pend;
        if (w_grant) w_pend_nxt[w_win] = 1'b0;
        w_pend_nxt = w_pend_nxt | w_cap;

        if (w_grant)                                   w_state_nxt = ST_DATA;
        else if (r_state == ST_DATA && S_HREADYOUT)    w_state_nxt = ST_IDLE;

        HREADYOUT_M0 = ~(r_pend[0] | w_err_stall[0] |
                         ((r_state == ST_DATA) & ~r_owner & ~S_HREADYOUT));
        HREADYOUT_M1 = ~(r_pend[1] | w_err_stall[1] |
                         ((r_state == ST_DATA) & r_owner & ~S_HREADYOUT));
        HRDATA_M0    = (r_state == ST_DATA && !r_owner) ? S_HRDATA : 32'h0;
        HRDATA_M1    = (r_state == ST_DATA &&  r_owner) ? S_HRDATA : 32'h0;
    end
endmodule
